// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch/data request ports and memory-controller bus shared by mem_arbiter
interface mem_arbiter_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 32
) ();
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ack;
  logic [DATA_W-1:0] i_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [1:0]        d_mode;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;

  logic [ADDR_W-1:0] m_addr;
  logic              m_we;
  logic [DATA_W-1:0] m_data_in;
  logic [1:0]        m_instr_mode;
  logic              m_enable;
  logic [DATA_W-1:0] m_data_out;
  logic              m_op_r;

  logic              busy;
  logic              err;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_mode, m_data_out, m_op_r,
    output i_ack, i_rdata, d_ack, d_rdata, m_addr, m_we, m_data_in, m_instr_mode,
           m_enable, busy, err
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_mode, m_data_out, m_op_r,
    input  i_ack, i_rdata, d_ack, d_rdata, m_addr, m_we, m_data_in, m_instr_mode,
           m_enable, busy, err
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (fetch/data) arbiter in front of a single memory controller
// Optional access timeout with err flag enabled by MEM_ARB_TIMEOUT_EN.
module mem_arbiter #(
  parameter int ADDR_W         = 24,
  parameter int DATA_W         = 32,
  parameter int DATA_PRIORITY  = 1,
  parameter int RELEASE_CYCLES = 2,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RELEASE = 2'd2
  } state_t;

  if (RELEASE_CYCLES < 1 || RELEASE_CYCLES > 15 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("mem_arbiter: RELEASE_CYCLES must be 1..15 and TIMEOUT_CYCLES at least 1");
  end

  state_t            state, state_nxt;
  logic [3:0]        rel_cnt, rel_cnt_nxt;
  logic              last_grant, last_grant_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic              we_q, we_nxt;
  logic [DATA_W-1:0] wdata_q, wdata_nxt;
  logic [1:0]        mode_q, mode_nxt;
  logic              enable_q, enable_nxt;
  logic              i_ack_q, i_ack_nxt;
  logic              d_ack_q, d_ack_nxt;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_nxt;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_nxt;
  logic              busy_q, busy_nxt;
  logic              err_q, err_nxt;
  logic              pick_d;
  logic              timed_out;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;

  // Counter sits at zero outside ACCESS so it is cleared on every entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                tmo_cnt <= '0;
    else if (state == ACCESS)  tmo_cnt <= tmo_cnt + 1'b1;
    else                       tmo_cnt <= '0;
  end

  assign timed_out = (state == ACCESS) && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  assign timed_out = 1'b0;
`endif

  always_comb begin
    state_nxt      = state;
    rel_cnt_nxt    = rel_cnt;
    last_grant_nxt = last_grant;
    addr_nxt       = addr_q;
    we_nxt         = we_q;
    wdata_nxt      = wdata_q;
    mode_nxt       = mode_q;
    enable_nxt     = enable_q;
    i_ack_nxt      = 1'b0;
    d_ack_nxt      = 1'b0;
    i_rdata_nxt    = i_rdata_q;
    d_rdata_nxt    = d_rdata_q;
    busy_nxt       = busy_q;
    err_nxt        = 1'b0;
    // last_grant=1 means data was served last, so round-robin hands a tie to fetch.
    pick_d = bus.d_req && (!bus.i_req || (DATA_PRIORITY != 0) || !last_grant);

    case (state)
      IDLE: begin
        if (bus.i_req || bus.d_req) begin
          state_nxt      = ACCESS;
          enable_nxt     = 1'b1;
          busy_nxt       = 1'b1;
          last_grant_nxt = pick_d;
          if (pick_d) begin
            addr_nxt  = bus.d_addr;
            we_nxt    = bus.d_we;
            wdata_nxt = bus.d_wdata;
            mode_nxt  = bus.d_mode;
          end else begin
            addr_nxt  = bus.i_addr;
            we_nxt    = 1'b0;
            wdata_nxt = '0;
            mode_nxt  = 2'b00;
          end
        end
      end
      ACCESS: begin
        if (bus.m_op_r || timed_out) begin
          state_nxt   = RELEASE;
          enable_nxt  = 1'b0;
          rel_cnt_nxt = 4'(RELEASE_CYCLES - 1);
          err_nxt     = !bus.m_op_r;
          if (last_grant) begin
            d_ack_nxt = 1'b1;
            if (!bus.m_op_r) d_rdata_nxt = '0;
            else if (!we_q)  d_rdata_nxt = bus.m_data_out;
          end else begin
            i_ack_nxt   = 1'b1;
            i_rdata_nxt = bus.m_op_r ? bus.m_data_out : '0;
          end
        end
      end
      RELEASE: begin
        if (rel_cnt == 4'd0) begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
        end else begin
          rel_cnt_nxt = rel_cnt - 4'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      rel_cnt    <= 4'd0;
      last_grant <= 1'b0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      mode_q     <= 2'b00;
      enable_q   <= 1'b0;
      i_ack_q    <= 1'b0;
      d_ack_q    <= 1'b0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state      <= state_nxt;
      rel_cnt    <= rel_cnt_nxt;
      last_grant <= last_grant_nxt;
      addr_q     <= addr_nxt;
      we_q       <= we_nxt;
      wdata_q    <= wdata_nxt;
      mode_q     <= mode_nxt;
      enable_q   <= enable_nxt;
      i_ack_q    <= i_ack_nxt;
      d_ack_q    <= d_ack_nxt;
      i_rdata_q  <= i_rdata_nxt;
      d_rdata_q  <= d_rdata_nxt;
      busy_q     <= busy_nxt;
      err_q      <= err_nxt;
    end
  end

  assign bus.m_addr       = addr_q;
  assign bus.m_we         = we_q;
  assign bus.m_data_in    = wdata_q;
  assign bus.m_instr_mode = mode_q;
  assign bus.m_enable     = enable_q;
  assign bus.i_ack        = i_ack_q;
  assign bus.d_ack        = d_ack_q;
  assign bus.i_rdata      = i_rdata_q;
  assign bus.d_rdata      = d_rdata_q;
  assign bus.busy         = busy_q;
  assign bus.err          = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed bench for mem_arbiter (round-robin and data-priority instances)
module tb_mem_arbiter;
  localparam int AW = 24;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ifa ();
  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ifp ();

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DATA_PRIORITY(0), .RELEASE_CYCLES(2),
                .TIMEOUT_CYCLES(16)) u_dut (.clk(clk), .reset(reset), .bus(ifa));
  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DATA_PRIORITY(1), .RELEASE_CYCLES(2),
                .TIMEOUT_CYCLES(16)) u_pri (.clk(clk), .reset(reset), .bus(ifp));

  int n_checks = 0;
  int n_fail   = 0;

  // Controller models: op_r pulses on the dly-th cycle of enable (dly=0 never answers).
  int            dly_a = 1, dly_p = 2, cnt_a = 0, cnt_p = 0;
  logic          op_a = 1'b0, op_p = 1'b0, stray_a = 1'b0;
  logic [DW-1:0] data_a = '0, data_p = '0;
  assign ifa.m_op_r     = op_a | stray_a;
  assign ifa.m_data_out = data_a;
  assign ifp.m_op_r     = op_p;
  assign ifp.m_data_out = data_p;

  always @(negedge clk) begin
    if (!ifa.m_enable) begin cnt_a = 0; op_a = 1'b0; end
    else if (op_a) op_a = 1'b0;
    else begin cnt_a++; if (dly_a != 0 && cnt_a == dly_a) op_a = 1'b1; end
  end

  always @(negedge clk) begin
    if (!ifp.m_enable) begin cnt_p = 0; op_p = 1'b0; end
    else if (op_p) op_p = 1'b0;
    else begin cnt_p++; if (dly_p != 0 && cnt_p == dly_p) op_p = 1'b1; end
  end

  task automatic wait_ack_a(input bit dport, input int limit, output int n);
    n = -1;
    for (int k = 1; k <= limit && n < 0; k++) begin
      @(negedge clk);
      if ((dport ? ifa.d_ack : ifa.i_ack) === 1'b1) n = k;
    end
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b0;
    ifa.i_req = 1'b1; ifa.i_addr = 24'h000111;
    ifa.d_req = 1'b1; ifa.d_addr = 24'h000222; ifa.d_we = 1'b0;
    ifa.d_wdata = 32'h00000055; ifa.d_mode = 2'b00;
    data_a = 32'hA5A50001; dly_a = 3;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({ifa.m_enable, ifa.m_we, ifa.m_addr, ifa.m_data_in, ifa.m_instr_mode} !== '0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got en=%b we=%b addr=%h din=%h mode=%b want all 0",
               ifa.m_enable, ifa.m_we, ifa.m_addr, ifa.m_data_in, ifa.m_instr_mode);
    end
    n_checks++;
    if ({ifa.i_ack, ifa.d_ack, ifa.busy, ifa.err} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_status: got i_ack=%b d_ack=%b busy=%b err=%b want 0",
               ifa.i_ack, ifa.d_ack, ifa.busy, ifa.err);
    end
    n_checks++;
    if ({ifa.i_rdata, ifa.d_rdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_rdata: got i=%h d=%h want 0", ifa.i_rdata, ifa.d_rdata);
    end
    n_checks++;
    if ({ifp.m_enable, ifp.busy, ifp.m_addr} !== '0) begin
      n_fail++;
      $display("FAIL reset_pri: got en=%b busy=%b addr=%h want 0", ifp.m_enable, ifp.busy, ifp.m_addr);
    end
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({ifa.m_enable, ifa.busy, ifa.m_addr} !== {1'b1, 1'b1, 24'h000222}) begin
      n_fail++;
      $display("FAIL reset_first_grant: got en=%b busy=%b addr=%h want 1 1 000222",
               ifa.m_enable, ifa.busy, ifa.m_addr);
    end
    wait_ack_a(1'b1, 10, n);
    n_checks++;
    if (n !== 3) begin n_fail++; $display("FAIL reset_d_ack_latency: got %0d want 3", n); end
    n_checks++;
    if (ifa.d_rdata !== 32'hA5A50001) begin
      n_fail++; $display("FAIL reset_d_rdata: got %h want a5a50001", ifa.d_rdata);
    end
    ifa.d_req = 1'b0;
    wait_ack_a(1'b0, 20, n);
    n_checks++;
    if (n !== 6) begin n_fail++; $display("FAIL reset_loser_served: got %0d want 6", n); end
    ifa.i_req = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_fetch_read();
    int n;
    ifa.i_addr = 24'h000310; data_a = 32'hDEADBEEF; dly_a = 64; ifa.i_req = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({ifa.m_enable, ifa.m_we, ifa.m_instr_mode, ifa.m_addr, ifa.m_data_in} !==
        {1'b1, 1'b0, 2'b00, 24'h000310, 32'h0}) begin
      n_fail++;
      $display("FAIL fetch_bus: got en=%b we=%b mode=%b addr=%h din=%h want 1 0 00 000310 0",
               ifa.m_enable, ifa.m_we, ifa.m_instr_mode, ifa.m_addr, ifa.m_data_in);
    end
    wait_ack_a(1'b0, 100, n);
    n_checks++;
    if (n !== 64) begin n_fail++; $display("FAIL fetch_latency: got %0d want 64", n); end
    n_checks++;
    if ({ifa.i_rdata, ifa.m_enable, ifa.d_ack} !== {32'hDEADBEEF, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL fetch_ack_cycle: got rdata=%h en=%b d_ack=%b want deadbeef 0 0",
               ifa.i_rdata, ifa.m_enable, ifa.d_ack);
    end
    ifa.i_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({ifa.i_ack, ifa.m_enable, ifa.busy} !== 3'b001) begin
      n_fail++;
      $display("FAIL fetch_release1: got ack=%b en=%b busy=%b want 0 0 1", ifa.i_ack, ifa.m_enable, ifa.busy);
    end
    @(negedge clk);
    n_checks++;
    if ({ifa.i_ack, ifa.m_enable, ifa.busy, ifa.i_rdata} !== {3'b000, 32'hDEADBEEF}) begin
      n_fail++;
      $display("FAIL fetch_idle: got ack=%b en=%b busy=%b rdata=%h want 0 0 0 deadbeef",
               ifa.i_ack, ifa.m_enable, ifa.busy, ifa.i_rdata);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_byte_store();
    int n;
    data_a = 32'h12345678; dly_a = 5;
    ifa.d_we = 1'b1; ifa.d_addr = 24'h000200; ifa.d_wdata = 32'h000001AA; ifa.d_mode = 2'b01;
    ifa.d_req = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({ifa.m_we, ifa.m_instr_mode, ifa.m_addr, ifa.m_data_in} !==
        {1'b1, 2'b01, 24'h000200, 32'h000001AA}) begin
      n_fail++;
      $display("FAIL store_bus: got we=%b mode=%b addr=%h din=%h want 1 01 000200 000001aa",
               ifa.m_we, ifa.m_instr_mode, ifa.m_addr, ifa.m_data_in);
    end
    wait_ack_a(1'b1, 20, n);
    n_checks++;
    if (n !== 5) begin n_fail++; $display("FAIL store_latency: got %0d want 5", n); end
    n_checks++;
    if ({ifa.d_rdata, ifa.i_ack} !== {32'hA5A50001, 1'b0}) begin
      n_fail++;
      $display("FAIL store_rdata_kept: got d_rdata=%h i_ack=%b want a5a50001 0", ifa.d_rdata, ifa.i_ack);
    end
    ifa.d_req = 1'b0; ifa.d_we = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_stray_op_r();
    int n;
    stray_a = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_checks++;
      if ({ifa.i_ack, ifa.d_ack, ifa.m_enable, ifa.busy} !== 4'b0000) begin
        n_fail++;
        $display("FAIL stray_idle: got i_ack=%b d_ack=%b en=%b busy=%b want 0",
                 ifa.i_ack, ifa.d_ack, ifa.m_enable, ifa.busy);
      end
    end
    stray_a = 1'b0;
    ifa.i_addr = 24'h000320; data_a = 32'h0BADF00D; dly_a = 3; ifa.i_req = 1'b1;
    @(negedge clk);
    wait_ack_a(1'b0, 10, n);
    n_checks++;
    if (n !== 3) begin n_fail++; $display("FAIL stray_fetch_latency: got %0d want 3", n); end
    ifa.i_req = 1'b0;
    data_a = 32'h99999999; stray_a = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_checks++;
      if ({ifa.i_ack, ifa.d_ack, ifa.i_rdata} !== {2'b00, 32'h0BADF00D}) begin
        n_fail++;
        $display("FAIL stray_release: got i_ack=%b d_ack=%b rdata=%h want 0 0 0badf00d",
                 ifa.i_ack, ifa.d_ack, ifa.i_rdata);
      end
    end
    stray_a = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_tie_round_robin();
    int ph, t;
    logic exp_en, exp_d, exp_i, exp_busy;
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    ifa.i_addr = 24'h000A00; ifa.d_addr = 24'h000D00; ifa.d_we = 1'b0; ifa.d_mode = 2'b10;
    dly_a = 2; data_a = 32'h11112222;
    ifa.i_req = 1'b1; ifa.d_req = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      ph = c % 5; t = c / 5;
      exp_en = (ph < 2); exp_busy = (ph != 4);
      exp_d = (ph == 2) && (t % 2 == 0);
      exp_i = (ph == 2) && (t % 2 == 1);
      n_checks++;
      if ({ifa.m_enable, ifa.d_ack, ifa.i_ack, ifa.busy} !== {exp_en, exp_d, exp_i, exp_busy}) begin
        n_fail++;
        $display("FAIL tie_trace c=%0d: got en/d_ack/i_ack/busy=%b%b%b%b want %b%b%b%b", c,
                 ifa.m_enable, ifa.d_ack, ifa.i_ack, ifa.busy, exp_en, exp_d, exp_i, exp_busy);
      end
      if (exp_en) begin
        n_checks++;
        if ({ifa.m_addr, ifa.m_instr_mode} !== ((t % 2 == 0) ? {24'h000D00, 2'b10} : {24'h000A00, 2'b00})) begin
          n_fail++;
          $display("FAIL tie_winner c=%0d: got addr=%h mode=%b want %s", c, ifa.m_addr,
                   ifa.m_instr_mode, (t % 2 == 0) ? "data 000d00 10" : "fetch 000a00 00");
        end
      end
    end
    ifa.i_req = 1'b0; ifa.d_req = 1'b0; ifa.d_mode = 2'b00;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_data_priority();
    int ph;
    logic exp_en, exp_d;
    ifp.i_addr = 24'h0000F0; ifp.d_addr = 24'h0000D0; ifp.d_we = 1'b0;
    ifp.d_wdata = '0; ifp.d_mode = 2'b00; dly_p = 2; data_p = 32'h00000077;
    ifp.i_req = 1'b1; ifp.d_req = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      ph = c % 5; exp_en = (ph < 2); exp_d = (ph == 2);
      n_checks++;
      if ({ifp.m_enable, ifp.d_ack, ifp.i_ack} !== {exp_en, exp_d, 1'b0}) begin
        n_fail++;
        $display("FAIL prio_trace c=%0d: got en/d_ack/i_ack=%b%b%b want %b%b0", c,
                 ifp.m_enable, ifp.d_ack, ifp.i_ack, exp_en, exp_d);
      end
      if (exp_en) begin
        n_checks++;
        if (ifp.m_addr !== 24'h0000D0) begin
          n_fail++; $display("FAIL prio_winner c=%0d: got addr=%h want 0000d0", c, ifp.m_addr);
        end
      end
    end
    ifp.i_req = 1'b0; ifp.d_req = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid_access();
    int n;
    ifa.i_addr = 24'h000ABC; data_a = 32'h5A5A5A5A; dly_a = 25; ifa.i_req = 1'b1;
    @(negedge clk);
    repeat (20) @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++;
    if ({ifa.m_enable, ifa.busy, ifa.i_ack} !== 3'b000) begin
      n_fail++;
      $display("FAIL midreset_drop: got en=%b busy=%b ack=%b want 0 0 0", ifa.m_enable, ifa.busy, ifa.i_ack);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({ifa.m_enable, ifa.m_addr} !== {1'b1, 24'h000ABC}) begin
      n_fail++;
      $display("FAIL midreset_regrant: got en=%b addr=%h want 1 000abc", ifa.m_enable, ifa.m_addr);
    end
    wait_ack_a(1'b0, 40, n);
    n_checks++;
    if (n !== 25) begin n_fail++; $display("FAIL midreset_latency: got %0d want 25", n); end
    n_checks++;
    if (ifa.i_rdata !== 32'h5A5A5A5A) begin
      n_fail++; $display("FAIL midreset_rdata: got %h want 5a5a5a5a", ifa.i_rdata);
    end
    ifa.i_req = 1'b0;
    repeat (3) @(negedge clk);
  endtask

`ifdef MEM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    dly_a = 0; data_a = 32'hCAFEF00D;
    ifa.d_we = 1'b0; ifa.d_mode = 2'b00; ifa.d_addr = 24'h000444; ifa.d_req = 1'b1;
    @(negedge clk);
    wait_ack_a(1'b1, 40, n);
    n_checks++;
    if (n !== 16) begin n_fail++; $display("FAIL timeout_latency: got %0d want 16", n); end
    n_checks++;
    if ({ifa.err, ifa.d_rdata, ifa.m_enable} !== {1'b1, 32'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL timeout_ack: got err=%b rdata=%h en=%b want 1 0 0", ifa.err, ifa.d_rdata, ifa.m_enable);
    end
    ifa.d_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({ifa.err, ifa.d_ack} !== 2'b00) begin
      n_fail++; $display("FAIL timeout_pulse: got err=%b ack=%b want 0 0", ifa.err, ifa.d_ack);
    end
    repeat (2) @(negedge clk);
    dly_a = 16; ifa.d_req = 1'b1;
    @(negedge clk);
    wait_ack_a(1'b1, 40, n);
    n_checks++;
    if (n !== 16) begin n_fail++; $display("FAIL timeout_race_latency: got %0d want 16", n); end
    n_checks++;
    if ({ifa.err, ifa.d_rdata} !== {1'b0, 32'hCAFEF00D}) begin
      n_fail++;
      $display("FAIL timeout_race: got err=%b rdata=%h want 0 cafef00d", ifa.err, ifa.d_rdata);
    end
    ifa.d_req = 1'b0;
    repeat (3) @(negedge clk);
  endtask
`else
  task automatic test_no_timeout();
    logic seen;
    seen = 1'b0;
    dly_a = 0; ifa.d_we = 1'b0; ifa.d_addr = 24'h000444; ifa.d_req = 1'b1;
    repeat (40) begin
      @(negedge clk);
      seen = seen | ifa.d_ack | ifa.i_ack | ifa.err;
    end
    n_checks++;
    if ({seen, ifa.m_enable, ifa.busy} !== 3'b011) begin
      n_fail++;
      $display("FAIL no_timeout_wait: got ack_or_err=%b en=%b busy=%b want 0 1 1", seen, ifa.m_enable, ifa.busy);
    end
    ifa.d_req = 1'b0;
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    ifa.i_req = 1'b0; ifa.i_addr = '0; ifa.d_req = 1'b0; ifa.d_we = 1'b0;
    ifa.d_addr = '0; ifa.d_wdata = '0; ifa.d_mode = 2'b00;
    ifp.i_req = 1'b0; ifp.i_addr = '0; ifp.d_req = 1'b0; ifp.d_we = 1'b0;
    ifp.d_addr = '0; ifp.d_wdata = '0; ifp.d_mode = 2'b00;
    test_reset();
    test_fetch_read();
    test_byte_store();
    test_stray_op_r();
    test_tie_round_robin();
    test_data_priority();
    test_reset_mid_access();
`ifdef MEM_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter that shares the single memory controller between the core's instruction-fetch port and its load/store data port.
- Accepts one request at a time and latches its fields.
- Drives the controller's addr/we/data_in/instr_mode/enable interface and waits for op_r.
- Returns read data with a one-cycle ack, then holds enable low so the controller returns to its idle state before the next grant.

Parameters:
- ADDR_W, 24, address width, matches the controller address bus.
- DATA_W, 32, data width.
- DATA_PRIORITY, 1, 1 = data port always wins a tie; 0 = round-robin on ties.
- RELEASE_CYCLES, 2, cycles enable is held low after each transaction (legal range 1..15).
- TIMEOUT_CYCLES, 256, ACCESS cycles before abort; used only with the optional feature.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- i_req  in  1  fetch request; held with i_addr stable until i_ack.
- i_addr  in  ADDR_W  fetch address.
- i_ack  out  1  one-cycle completion pulse for the fetch port.
- i_rdata  out  DATA_W  fetched word; valid while i_ack=1 and held until the next fetch ack.
- d_req  in  1  data request; held with fields stable until d_ack.
- d_we  in  1  1 = store.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_mode  in  2  00 word, 01 byte, 10 half.
- d_ack  out  1  one-cycle completion pulse for the data port.
- d_rdata  out  DATA_W  load data; valid while d_ack=1 and held until the next data ack.
- m_addr  out  ADDR_W  to controller addr.
- m_we  out  1  to controller we.
- m_data_in  out  DATA_W  to controller data_in.
- m_instr_mode  out  2  to controller instr_mode.
- m_enable  out  1  to controller enable.
- m_data_out  in  DATA_W  from controller data_out.
- m_op_r  in  1  from controller op_r.
- busy  out  1  high in every state except IDLE.
- err  out  1  one-cycle timeout flag, coincident with the ack; tied 0 when the optional feature is compiled out.

Behaviour:
- All outputs are registered.
- Reset (reset=0, asynchronous) clears every output and all state to 0: m_enable, m_we, m_addr, m_data_in, m_instr_mode, i_ack, d_ack, i_rdata, d_rdata, busy, err.
- Reset state: state=IDLE, release counter=0, last_grant=I.
- Reset asserted mid-transaction drops the transaction with no ack; the requester re-issues it after reset.
- States are IDLE, ACCESS, RELEASE.
- IDLE:
  - If i_req or d_req is high at an edge, select the winner, latch its fields into the m_* registers, set m_enable=1, busy=1, record last_grant, and go to ACCESS.
  - Fetch grants drive m_we=0, m_instr_mode=00, m_data_in=0.
- Tie resolution (both requests high):
  - DATA_PRIORITY=1: data wins.
  - DATA_PRIORITY=0: the port opposite last_grant wins, so the first tie after reset goes to data.
- ACCESS:
  - m_* outputs are held constant.
  - On the first edge with m_op_r=1: capture m_data_out into the winner's rdata (stores capture nothing), pulse the winner's ack for exactly one cycle, set m_enable=0, load the release counter, and go to RELEASE.
  - m_op_r arriving in IDLE or RELEASE is ignored.
- RELEASE:
  - Acks return to 0, m_enable stays 0, and the counter decrements.
  - When the counter expires, go to IDLE and set busy=0.
- Requesters must deassert req in the cycle after their ack. A req still high when IDLE is reached is treated as a new request.
- Latency:
  - From a req sampled in IDLE, m_enable rises 1 cycle later.
  - Ack follows 1 cycle after the m_op_r edge.
  - Back-to-back grants are spaced by at least RELEASE_CYCLES+1 idle-enable cycles.
- Only one transaction is outstanding at a time; no queueing.
- A request arriving during ACCESS or RELEASE waits, so a losing requester is served next.

Optional Feature:
- Macro MEM_ARB_TIMEOUT_EN.
- Defined:
  - A counter of ACCESS cycles is cleared on entry to ACCESS.
  - When it reaches TIMEOUT_CYCLES with m_op_r still 0, the arbiter acks the winner with rdata=0 and err=1 for that one cycle, sets m_enable=0, and goes to RELEASE.
  - If m_op_r=1 on the same edge the timeout expires, the normal completion wins and err=0.
- Undefined: ACCESS waits for m_op_r indefinitely, no counter logic is generated, and err is constant 0.

Test Plan:
1. Reset: hold reset=0 with i_req=d_req=1 -> all outputs 0; release reset -> data is granted first (m_addr=d_addr).
2. Fetch read: i_req=1, i_addr=24'h000310; model m_op_r after 64 cycles with m_data_out=32'hDEADBEEF -> m_we=0, m_instr_mode=00, i_ack pulses once with i_rdata=32'hDEADBEEF, then m_enable low for 2 cycles.
3. Byte store: d_req=1, d_we=1, d_addr=24'h000200, d_wdata=32'h000001AA, d_mode=01 -> m_data_in=32'h000001AA, m_we=1, m_instr_mode=01; d_ack after m_op_r; d_rdata unchanged.
4. Tie with DATA_PRIORITY=0, both ports requesting continuously -> grants alternate D, I, D, I; each ack is a single cycle; no grant starts while busy=1.
5. Reset mid-ACCESS (reset=0 for 1 cycle at cycle 20 of a fetch) -> m_enable=0 immediately, no i_ack; the fetch restarts after reset with its original i_addr.
6. MEM_ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, m_op_r never asserted -> d_ack=1 and err=1 on the same cycle, 16 cycles after m_enable rises, d_rdata=0; m_op_r on cycle 16 instead gives err=0 with captured data.
